// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
//   Groups the fetch-stage bus signals: the instruction-memory request/response
//   pair and the decode-side valid/ready output.
//   Ports (signals):
//     imem_req, imem_addr  : fetch request and address (stage -> memory)
//     imem_rdata           : instruction, valid the cycle after imem_req
//     out_valid, out_ready : decode handshake
//     out_instr, out_pc, out_npc : head-of-queue instruction, PC, PC + step
//   Modports: master = fetch stage, slave = memory/decode environment.
interface if_prefetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_npc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_npc,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_npc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction fetch stage with a prefetch queue. Issues sequential fetches to
//   a synchronous instruction memory (1-cycle read latency), buffers each
//   returned instruction with its PC and NPC, and presents the queue head to
//   decode. Any non-sequential pc_src flushes the queue and drops the
//   in-flight response.
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     pc_src                : 00 seq, 01 J target, 10 I target, 11 return addr
//     j_target, i_target, ret_addr : redirect addresses
//     bus (master)          : imem request/response and decode output
//     q_count               : occupied queue entries
//   Optional (macro FETCH_PERF_CNT_EN): perf_fetches, perf_flushes,
//     perf_stall_cycles, 32-bit wrapping event counters.
module if_prefetch_stage #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int PC_STEP  = 2,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                pc_src,
    input  logic [ADDR_W-1:0]         j_target,
    input  logic [ADDR_W-1:0]         i_target,
    input  logic [ADDR_W-1:0]         ret_addr,
    if_prefetch_stage_if.master       bus,
    output logic [$clog2(QDEPTH):0]   q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetches,
    output logic [31:0]               perf_flushes,
    output logic [31:0]               perf_stall_cycles
`endif
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_PC);
    localparam logic [CNT_W:0]    DEPTH_V = (CNT_W+1)'(QDEPTH);

    logic [ADDR_W-1:0]  fetch_pc;
    logic               inflight;
    logic [ADDR_W-1:0]  req_pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [INSTR_W-1:0] q_instr [QDEPTH];
    logic [ADDR_W-1:0]  q_pc    [QDEPTH];
    logic [ADDR_W-1:0]  q_npc   [QDEPTH];

    logic               redirect;
    logic               imem_req;
    logic               out_valid;
    logic               pop;
    logic               push;
    logic [CNT_W:0]     occupancy;
    logic [PTR_W-1:0]   rd_ptr_popped;

    // Handshake: decode takes the head on any cycle where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // head fields stay stable while out_valid is high and out_ready is low.
    assign redirect  = (pc_src != 2'b00);
    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = inflight && !redirect;

    // Free space counts the outstanding response but never a same-cycle pop,
    // so a push can always land without checking for room.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight);
    assign imem_req  = !reset && !redirect && (occupancy < DEPTH_V);

    assign rd_ptr_popped = rd_ptr + PTR_W'(pop);

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = q_instr[rd_ptr];
    assign bus.out_pc    = q_pc[rd_ptr];
    assign bus.out_npc   = q_npc[rd_ptr];
    assign q_count       = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_V;
            inflight <= 1'b0;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_npc[i]   <= '0;
            end
        end else begin
            // A redirect forces imem_req low, so inflight clears and the
            // response arriving this edge is dropped via push=0.
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end

            case (pc_src)
                2'b01:   fetch_pc <= j_target;
                2'b10:   fetch_pc <= i_target;
                2'b11:   fetch_pc <= ret_addr;
                default: if (imem_req) fetch_pc <= fetch_pc + STEP_V;
            endcase

            if (redirect) begin
                // Honour a same-cycle pop, then discard everything behind it.
                rd_ptr <= rd_ptr_popped;
                wr_ptr <= rd_ptr_popped;
                count  <= '0;
            end else begin
                if (push) begin
                    q_instr[wr_ptr] <= bus.imem_rdata;
                    q_pc[wr_ptr]    <= req_pc;
                    q_npc[wr_ptr]   <= req_pc + STEP_V;
                    wr_ptr          <= wr_ptr + PTR_W'(1);
                end
                rd_ptr <= rd_ptr_popped;
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetches      <= '0;
            perf_flushes      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (imem_req) perf_fetches <= perf_fetches + 32'd1;
            if (redirect) perf_flushes <= perf_flushes + 32'd1;
            if (out_valid && !bus.out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage
//   Directed bench for if_prefetch_stage with default parameters. A small
//   synchronous memory model returns (address ^ 16'hA5A5) one cycle after each
//   request. Inputs change 1 time unit after a posedge; outputs are checked
//   there as well, away from the active edge.
module tb_if_prefetch_stage;
    logic        clk;
    logic        reset;
    logic [1:0]  pc_src;
    logic [15:0] j_target;
    logic [15:0] i_target;
    logic [15:0] ret_addr;
    logic [2:0]  q_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_flushes;
    logic [31:0] perf_stall_cycles;
`endif

    int tests;
    int fails;

    if_prefetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    if_prefetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .pc_src   (pc_src),
        .j_target (j_target),
        .i_target (i_target),
        .ret_addr (ret_addr),
        .bus      (bus),
        .q_count  (q_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetches      (perf_fetches),
        .perf_flushes      (perf_flushes),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory model, 1-cycle read latency
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ 16'hA5A5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        pc_src = 2'b00;
        j_target = '0;
        i_target = '0;
        ret_addr = '0;
        bus.out_ready = 1'b1;

        // reset state
        #2;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_count", q_count, 3'd0);
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_addr", bus.imem_addr, 16'h0000);
        check("rst_instr", bus.out_instr, 16'h0000);
        check("rst_pc", bus.out_pc, 16'h0000);
        check("rst_npc", bus.out_npc, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // streaming with out_ready=1
        check("s_req0", bus.imem_req, 1'b1);
        check("s_addr0", bus.imem_addr, 16'h0000);
        tick();
        check("s_addr1", bus.imem_addr, 16'h0002);
        check("s_valid1", bus.out_valid, 1'b0);
        tick();
        check("s_valid2", bus.out_valid, 1'b1);
        check("s_pc2", bus.out_pc, 16'h0000);
        check("s_npc2", bus.out_npc, 16'h0002);
        check("s_instr2", bus.out_instr, 16'hA5A5);
        check("s_addr2", bus.imem_addr, 16'h0004);
        tick();
        check("s_pc3", bus.out_pc, 16'h0002);
        check("s_npc3", bus.out_npc, 16'h0004);
        check("s_instr3", bus.out_instr, 16'hA5A7);
        check("s_addr3", bus.imem_addr, 16'h0006);
        check("s_cnt3", q_count, 3'd1);
        tick();
        check("s_pc4", bus.out_pc, 16'h0004);
        check("s_npc4", bus.out_npc, 16'h0006);

        // stall until q_count=3 with a fetch still in flight, then reset
        bus.out_ready = 1'b0;
        tick();
        check("st_cnt5", q_count, 3'd2);
        tick();
        check("st_cnt6", q_count, 3'd3);
        check("st_req6", bus.imem_req, 1'b0);
        check("st_pc6", bus.out_pc, 16'h0004);
        reset = 1'b1;
        #1;
        check("mr_valid", bus.out_valid, 1'b0);
        check("mr_count", q_count, 3'd0);
        check("mr_req", bus.imem_req, 1'b0);
        check("mr_addr", bus.imem_addr, 16'h0000);
        check("mr_pc", bus.out_pc, 16'h0000);
        tick();
        reset = 1'b0;
        #1;

        // refill with out_ready=0 held
        check("f_addr0", bus.imem_addr, 16'h0000);
        tick();
        check("f_valid1", bus.out_valid, 1'b0);
        tick();
        check("f_valid2", bus.out_valid, 1'b1);
        check("f_pc2", bus.out_pc, 16'h0000);
        tick();
        tick();
        check("f_req4", bus.imem_req, 1'b0);
        tick();
        check("f_cnt5", q_count, 3'd4);
        check("f_req5", bus.imem_req, 1'b0);
        check("f_addr5", bus.imem_addr, 16'h0008);
        tick();
        check("f_cnt6", q_count, 3'd4);
        check("f_pc6", bus.out_pc, 16'h0000);
        check("f_addr6", bus.imem_addr, 16'h0008);
        bus.out_ready = 1'b1;
        #1;
        check("f_req_pop", bus.imem_req, 1'b0);
        tick();
        check("d_pc1", bus.out_pc, 16'h0002);
        check("d_cnt1", q_count, 3'd3);
        check("d_req1", bus.imem_req, 1'b1);
        check("d_addr1", bus.imem_addr, 16'h0008);
        tick();
        check("d_pc2", bus.out_pc, 16'h0004);
        tick();
        check("d_pc3", bus.out_pc, 16'h0006);
        check("d_npc3", bus.out_npc, 16'h0008);
        tick();
        check("d_pc4", bus.out_pc, 16'h0008);
        check("d_instr4", bus.out_instr, 16'hA5AD);
        check("d_cnt4", q_count, 3'd2);

        // J-type redirect with queued entries and a fetch in flight
        bus.out_ready = 1'b0;
        pc_src = 2'b01;
        j_target = 16'h0040;
        #1;
        check("j_req_redir", bus.imem_req, 1'b0);
        tick();
        check("j_cnt", q_count, 3'd0);
        check("j_valid", bus.out_valid, 1'b0);
        check("j_addr", bus.imem_addr, 16'h0040);
        pc_src = 2'b00;
        bus.out_ready = 1'b1;
        #1;
        check("j_req", bus.imem_req, 1'b1);
        tick();
        check("j_valid1", bus.out_valid, 1'b0);
        tick();
        check("j_valid2", bus.out_valid, 1'b1);
        check("j_pc2", bus.out_pc, 16'h0040);
        check("j_npc2", bus.out_npc, 16'h0042);
        check("j_instr2", bus.out_instr, 16'hA5E5);
        tick();
        check("j_pc3", bus.out_pc, 16'h0042);

        // back-to-back redirects, with a pop in the first one
        pc_src = 2'b10;
        i_target = 16'h0010;
        ret_addr = 16'h0020;
        #1;
        check("b_req0", bus.imem_req, 1'b0);
        tick();
        check("b_cnt", q_count, 3'd0);
        check("b_addr_i", bus.imem_addr, 16'h0010);
        pc_src = 2'b11;
        #1;
        check("b_req1", bus.imem_req, 1'b0);
        tick();
        pc_src = 2'b00;
        #1;
        check("b_req2", bus.imem_req, 1'b1);
        check("b_addr_r", bus.imem_addr, 16'h0020);
        tick();
        check("b_valid1", bus.out_valid, 1'b0);
        tick();
        check("b_pc", bus.out_pc, 16'h0020);
        check("b_cnt2", q_count, 3'd1);

        // address wrap at the top of the space
        pc_src = 2'b01;
        j_target = 16'hFFFE;
        tick();
        pc_src = 2'b00;
        #1;
        check("w_addr0", bus.imem_addr, 16'hFFFE);
        tick();
        check("w_addr1", bus.imem_addr, 16'h0000);
        tick();
        check("w_pc0", bus.out_pc, 16'hFFFE);
        check("w_npc0", bus.out_npc, 16'h0000);
        check("w_instr0", bus.out_instr, 16'h5A5B);
        tick();
        check("w_pc1", bus.out_pc, 16'h0000);
        check("w_npc1", bus.out_npc, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
